// File: rtl/npi_ict_pkg.sv
// Shared NPI interconnect write-path types: FSM encodings and the {len,nr} status entry.
package npi_ict_pkg;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_DATA = 4'd1,
      S_POP  = 4'd2
   } state_t;

   localparam int LEN_W     = 6;
   localparam int NR_W      = 3;
   localparam int STS_W     = LEN_W + NR_W;
   localparam int STS_DEPTH = 8;
   localparam int STS_AW    = 3;

   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [NR_W-1:0]  nr;
   } sts_t;

endpackage

// File: rtl/srl16e_fifo_protect.sv
// Small show-ahead FIFO; DOUT is the head entry with no read latency.
// Writes when full and reads when empty are ignored; ALMOST_FULL at depth-1 lets the writer stop in time.
module srl16e_fifo_protect #(
   parameter int c_width  = 9,
   parameter int c_awidth = 3,
   parameter int c_depth  = 8
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               WR_EN,
   input  logic               RD_EN,
   input  logic [c_width-1:0] DIN,
   output logic [c_width-1:0] DOUT,
   output logic               ALMOST_FULL,
   output logic               EMPTY
);

   logic [c_width-1:0]  mem_q [c_depth];
   logic [c_width-1:0]  mem_d [c_depth];
   logic [c_awidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_awidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_awidth:0]   count_q, count_d;
   logic                full;
   logic                wr_ok;
   logic                rd_ok;

   assign full        = (count_q == (c_awidth+1)'(c_depth));
   assign EMPTY       = (count_q == '0);
   assign ALMOST_FULL = (count_q >= (c_awidth+1)'(c_depth - 1));
   assign DOUT        = mem_q[rd_ptr_q];
   assign wr_ok       = WR_EN & ~full;
   assign rd_ok       = RD_EN & ~EMPTY;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) begin
         mem_d[wr_ptr_q] = DIN;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous write and read leave the count unchanged.
      if (wr_ok && !rd_ok) begin
         count_d = count_q + 1'b1;
      end else if (!wr_ok && rd_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/npi_ict_wr.sv
// NPI write-data mover: per queued {len,nr} burst, pops len words from port nr and pushes them to MPMC 2 cycles later.
// Pops pause while PIM_WrFIFO_AlmostFull is high (<=2 words in flight); NPI_ICT_WR_BE_EN passes per-word byte enables.
module npi_ict_wr
   import npi_ict_pkg::*;
#(
   parameter int C_PIM_DATA_WIDTH = 64
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          wrsts_wren,
   input  logic [LEN_W-1:0]              wrsts_len,
   input  logic [NR_W-1:0]               wrsts_nr,
   output logic                          wrsts_afull,
   output logic                          Port_WrFIFO_Pop,
   output logic [NR_W-1:0]               Port_WrFIFO_Pop_sel,
   input  logic [C_PIM_DATA_WIDTH-1:0]   Port_WrFIFO_Data,
`ifdef NPI_ICT_WR_BE_EN
   input  logic [C_PIM_DATA_WIDTH/8-1:0] Port_WrFIFO_BE,
`endif
   output logic                          PIM_WrFIFO_Push,
   output logic [C_PIM_DATA_WIDTH-1:0]   PIM_WrFIFO_Data,
   output logic [C_PIM_DATA_WIDTH/8-1:0] PIM_WrFIFO_BE,
   input  logic                          PIM_WrFIFO_AlmostFull,
   output logic                          PIM_WrFIFO_Flush,
   output logic [15:0]                   npi_ict_dbg
);

   localparam int BE_W = C_PIM_DATA_WIDTH / 8;

   state_t                      state_q, state_d;
   logic [LEN_W-1:0]            len_q, len_d;
   logic                        pop_d1_q, pop_d1_d;
   logic                        push_q, push_d;
   logic [C_PIM_DATA_WIDTH-1:0] data_q, data_d;
   logic [STS_W-1:0]            dout_raw;
   sts_t                        sts_dout;
   logic                        empty;
   logic                        rden;
   logic                        pop;

   srl16e_fifo_protect #(
      .c_width  (STS_W),
      .c_awidth (STS_AW),
      .c_depth  (STS_DEPTH)
   ) stsfifo (
      .Clk         (Clk),
      .Rst         (Rst),
      .WR_EN       (wrsts_wren),
      .RD_EN       (rden),
      .DIN         ({wrsts_len, wrsts_nr}),
      .DOUT        (dout_raw),
      .ALMOST_FULL (wrsts_afull),
      .EMPTY       (empty)
   );

   assign sts_dout = sts_t'(dout_raw);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      pop     = 1'b0;
      rden    = 1'b0;
      case (state_q)
         S_IDLE: begin
            len_d = sts_dout.len;
            if (!empty) begin
               // A zero-length entry is malformed: dequeue it without popping anything.
               state_d = (sts_dout.len != '0) ? S_DATA : S_POP;
            end
         end
         S_DATA: begin
            pop = ~PIM_WrFIFO_AlmostFull;
            if (pop) begin
               len_d = len_q - 1'b1;
               if (len_q == LEN_W'(1)) begin
                  state_d = S_POP;
               end
            end
         end
         S_POP: begin
            rden    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Port data arrives one cycle after the pop; capture it then so it lines up with the push.
   always_comb begin
      pop_d1_d = pop;
      push_d   = pop_d1_q;
      data_d   = pop_d1_q ? Port_WrFIFO_Data : data_q;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         pop_d1_q <= 1'b0;
         push_q   <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         pop_d1_q <= pop_d1_d;
         push_q   <= push_d;
         data_q   <= data_d;
      end
   end

`ifdef NPI_ICT_WR_BE_EN
   logic [BE_W-1:0] be_q, be_d;

   always_comb begin
      be_d = pop_d1_q ? Port_WrFIFO_BE : be_q;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         be_q <= '0;
      end else begin
         be_q <= be_d;
      end
   end

   assign PIM_WrFIFO_BE = be_q;
`else
   assign PIM_WrFIFO_BE = {BE_W{push_q}};
`endif

   assign Port_WrFIFO_Pop     = pop;
   assign Port_WrFIFO_Pop_sel = sts_dout.nr;
   assign PIM_WrFIFO_Push     = push_q;
   assign PIM_WrFIFO_Data     = data_q;
   assign PIM_WrFIFO_Flush    = 1'b0;
   assign npi_ict_dbg         = {dout_raw[7:0], wrsts_wren, wrsts_afull, rden, empty, state_q};

endmodule

// File: tb/tb_npi_ict_wr.sv
// Directed bench for npi_ict_wr: port-buffer model with one-cycle read latency plus a push scoreboard.
module tb_npi_ict_wr;

   localparam int DW = 64;
   localparam int BW = DW / 8;
`ifdef NPI_ICT_WR_BE_EN
   localparam logic [BW-1:0] EXP_BE = 8'h0F;
`else
   localparam logic [BW-1:0] EXP_BE = 8'hFF;
`endif

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          wrsts_wren = 1'b0;
   logic [5:0]    wrsts_len = '0;
   logic [2:0]    wrsts_nr = '0;
   logic          wrsts_afull;
   logic          Port_WrFIFO_Pop;
   logic [2:0]    Port_WrFIFO_Pop_sel;
   logic [DW-1:0] Port_WrFIFO_Data = '0;
`ifdef NPI_ICT_WR_BE_EN
   logic [BW-1:0] Port_WrFIFO_BE = 8'h0F;
`endif
   logic          PIM_WrFIFO_Push;
   logic [DW-1:0] PIM_WrFIFO_Data;
   logic [BW-1:0] PIM_WrFIFO_BE;
   logic          PIM_WrFIFO_AlmostFull = 1'b0;
   logic          PIM_WrFIFO_Flush;
   logic [15:0]   npi_ict_dbg;

   always #5 Clk = ~Clk;

   npi_ict_wr #(.C_PIM_DATA_WIDTH(DW)) dut (
      .Clk                   (Clk),
      .Rst                   (Rst),
      .wrsts_wren            (wrsts_wren),
      .wrsts_len             (wrsts_len),
      .wrsts_nr              (wrsts_nr),
      .wrsts_afull           (wrsts_afull),
      .Port_WrFIFO_Pop       (Port_WrFIFO_Pop),
      .Port_WrFIFO_Pop_sel   (Port_WrFIFO_Pop_sel),
      .Port_WrFIFO_Data      (Port_WrFIFO_Data),
`ifdef NPI_ICT_WR_BE_EN
      .Port_WrFIFO_BE        (Port_WrFIFO_BE),
`endif
      .PIM_WrFIFO_Push       (PIM_WrFIFO_Push),
      .PIM_WrFIFO_Data       (PIM_WrFIFO_Data),
      .PIM_WrFIFO_BE         (PIM_WrFIFO_BE),
      .PIM_WrFIFO_AlmostFull (PIM_WrFIFO_AlmostFull),
      .PIM_WrFIFO_Flush      (PIM_WrFIFO_Flush),
      .npi_ict_dbg           (npi_ict_dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int            cyc = 0;
   logic [DW-1:0] exp_q[$];
   int            pop_cyc_q[$];
   logic [2:0]    sel_log[$];
   int            pop_log_cyc[$];
   int            npush = 0;
   int            nspop = 0;
   int            seq[8];
   logic [BW-1:0] last_be = '0;

   function automatic logic [DW-1:0] mkword(input logic [2:0] nr, input int idx);
      return {16'hC0DE, 13'h0, nr, 32'(idx)};
   endfunction

   initial forever begin
      @(posedge Clk);
      cyc++;
   end

   // Port write buffers (data one cycle after pop) and push scoreboard.
   initial begin
      logic          popped;
      logic [DW-1:0] w;
      foreach (seq[i]) seq[i] = 0;
      forever begin
         @(negedge Clk);
         #2;
         popped = 1'b0;
         w      = '0;
         if (Port_WrFIFO_Pop) begin
            w = mkword(Port_WrFIFO_Pop_sel, seq[Port_WrFIFO_Pop_sel]);
            seq[Port_WrFIFO_Pop_sel]++;
            exp_q.push_back(w);
            pop_cyc_q.push_back(cyc);
            sel_log.push_back(Port_WrFIFO_Pop_sel);
            pop_log_cyc.push_back(cyc);
            popped = 1'b1;
         end
         if (PIM_WrFIFO_Push) begin
            npush++;
            last_be = PIM_WrFIFO_BE;
            if (exp_q.size() == 0) begin
               check_eq("push_unexpected", 64'd1, 64'd0);
            end else begin
               check_eq("push_data", PIM_WrFIFO_Data, exp_q.pop_front());
               check_eq("push_latency", 64'(cyc), 64'(pop_cyc_q.pop_front() + 2));
            end
            check_eq("push_be", 64'(PIM_WrFIFO_BE), 64'(EXP_BE));
         end
         if (npi_ict_dbg[3:0] == 4'd2) nspop++;
         @(posedge Clk);
         #1;
         Port_WrFIFO_Data = popped ? w : 64'hBAD0_BAD0_BAD0_BAD0;
      end
   end

   task automatic clear_logs();
      sel_log.delete();
      pop_log_cyc.delete();
      npush = 0;
      nspop = 0;
   endtask

   task automatic send(input int len, input int nr);
      @(negedge Clk);
      wrsts_wren = 1'b1;
      wrsts_len  = 6'(len);
      wrsts_nr   = 3'(nr);
      @(negedge Clk);
      wrsts_wren = 1'b0;
   endtask

   task automatic wait_pushes(input int target, input int budget, input string tag);
      int i = 0;
      while (npush < target && i < budget) begin
         @(negedge Clk);
         #3;
         i++;
      end
      check_eq(tag, 64'(npush >= target), 64'd1);
      repeat (4) @(negedge Clk);
      #3;
   endtask

   task automatic wait_pops(input int target, input int budget, input string tag);
      int i = 0;
      while (sel_log.size() < target && i < budget) begin
         @(negedge Clk);
         #3;
         i++;
      end
      check_eq(tag, 64'(sel_log.size() >= target), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      // Reset state
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      #3;
      check_eq("rst_push", 64'(PIM_WrFIFO_Push), 64'd0);
      check_eq("rst_pop", 64'(Port_WrFIFO_Pop), 64'd0);
      check_eq("rst_state", 64'(npi_ict_dbg[3:0]), 64'd0);
      check_eq("rst_empty", 64'(npi_ict_dbg[4]), 64'd1);
      check_eq("rst_afull", 64'(wrsts_afull), 64'd0);
      check_eq("rst_data", PIM_WrFIFO_Data, 64'd0);
      check_eq("rst_be", 64'(PIM_WrFIFO_BE), 64'd0);
      check_eq("rst_flush", 64'(PIM_WrFIFO_Flush), 64'd0);

      // T1 single burst
      clear_logs();
      send(4, 5);
      wait_pushes(4, 50, "t1_timeout");
      check_eq("t1_npush", 64'(npush), 64'd4);
      check_eq("t1_npop", 64'(sel_log.size()), 64'd4);
      foreach (sel_log[i]) check_eq("t1_sel", 64'(sel_log[i]), 64'd5);
      if (pop_log_cyc.size() == 4)
         check_eq("t1_consecutive", 64'(pop_log_cyc[3] - pop_log_cyc[0]), 64'd3);
      check_eq("t1_spop_cycles", 64'(nspop), 64'd1);

      // T2 backpressure on burst cycles 3-6
      clear_logs();
      send(8, 2);
      wait_pops(1, 20, "t2_first_pop");
      @(negedge Clk);
      @(negedge Clk);
      PIM_WrFIFO_AlmostFull = 1'b1;
      repeat (4) @(negedge Clk);
      PIM_WrFIFO_AlmostFull = 1'b0;
      wait_pushes(8, 60, "t2_timeout");
      check_eq("t2_npush", 64'(npush), 64'd8);
      check_eq("t2_npop", 64'(sel_log.size()), 64'd8);
      if (pop_log_cyc.size() == 8)
         check_eq("t2_span", 64'(pop_log_cyc[7] - pop_log_cyc[0]), 64'd11);
      check_eq("t2_leftover", 64'(exp_q.size()), 64'd0);

      // T3 eight queued bursts, nr 0..7, len 1..8
      clear_logs();
      PIM_WrFIFO_AlmostFull = 1'b1;
      for (int e = 0; e < 8; e++) begin
         @(negedge Clk);
         wrsts_wren = 1'b1;
         wrsts_len  = 6'(e + 1);
         wrsts_nr   = 3'(e);
      end
      @(negedge Clk);
      wrsts_wren = 1'b0;
      #3;
      check_eq("t3_afull", 64'(wrsts_afull), 64'd1);
      check_eq("t3_not_empty", 64'(npi_ict_dbg[4]), 64'd0);
      check_eq("t3_no_pop_held", 64'(sel_log.size()), 64'd0);
      @(negedge Clk);
      PIM_WrFIFO_AlmostFull = 1'b0;
      wait_pushes(36, 400, "t3_timeout");
      check_eq("t3_npush", 64'(npush), 64'd36);
      check_eq("t3_npop", 64'(sel_log.size()), 64'd36);
      idx = 0;
      for (int e = 0; e < 8; e++) begin
         for (int k = 0; k <= e; k++) begin
            if (idx < sel_log.size()) check_eq("t3_sel", 64'(sel_log[idx]), 64'(e));
            idx++;
         end
      end
      if (pop_log_cyc.size() >= 2)
         check_eq("t3_gap", 64'(pop_log_cyc[1] - pop_log_cyc[0]), 64'd3);
      check_eq("t3_afull_clear", 64'(wrsts_afull), 64'd0);
      check_eq("t3_empty", 64'(npi_ict_dbg[4]), 64'd1);

      // T4 zero-length entry is discarded
      clear_logs();
      send(0, 7);
      send(2, 3);
      wait_pushes(2, 50, "t4_timeout");
      check_eq("t4_npush", 64'(npush), 64'd2);
      check_eq("t4_npop", 64'(sel_log.size()), 64'd2);
      foreach (sel_log[i]) check_eq("t4_sel", 64'(sel_log[i]), 64'd3);
      check_eq("t4_spop_cycles", 64'(nspop), 64'd2);

      // T5 reset during word 3 of 6
      clear_logs();
      send(6, 1);
      wait_pops(3, 30, "t5_third_pop");
      Rst = 1'b1;
      @(negedge Clk);
      #3;
      check_eq("t5_push", 64'(PIM_WrFIFO_Push), 64'd0);
      check_eq("t5_pop", 64'(Port_WrFIFO_Pop), 64'd0);
      check_eq("t5_state", 64'(npi_ict_dbg[3:0]), 64'd0);
      check_eq("t5_empty", 64'(npi_ict_dbg[4]), 64'd1);
      Rst = 1'b0;
      @(negedge Clk);
      #3;
      check_eq("t5_push_cancel", 64'(PIM_WrFIFO_Push), 64'd0);
      exp_q.delete();
      pop_cyc_q.delete();
      repeat (5) @(negedge Clk);
      #3;
      check_eq("t5_npush", 64'(npush), 64'd1);
      check_eq("t5_npop", 64'(sel_log.size()), 64'd3);

      // T6 byte enables
      clear_logs();
      send(2, 4);
      wait_pushes(2, 50, "t6_timeout");
      check_eq("t6_be_push", 64'(last_be), 64'(EXP_BE));
`ifdef NPI_ICT_WR_BE_EN
      check_eq("t6_be_idle", 64'(PIM_WrFIFO_BE), 64'h0F);
`else
      check_eq("t6_be_idle", 64'(PIM_WrFIFO_BE), 64'h00);
`endif

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
